// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: read strobe, head byte and status.
// The receiver drives through 'slave'; the keyboard wrapper uses 'master'.
interface ps2_rx_fifo_if;
    logic       rdn;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport slave (
        input  rdn,
        output data,
        output ready,
        output overflow,
        output frame_err
    );

    modport master (
        output rdn,
        input  data,
        input  ready,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host deframer feeding a show-ahead byte FIFO.
// Pins are oversampled on clk; bytes are popped on a falling rdn edge.
module ps2_rx_fifo #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TONE = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_e;

    state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    sr_q, sr_d;
    logic          start_q, start_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [FIFO_AW:0] wr_q, wr_d;
    logic [FIFO_AW:0] rd_q, rd_d;
    logic          rdn_q;
    logic          c1_q, c2_q, c3_q;
    logic          d1_q, d2_q;
    logic [7:0]    mem_q [DEPTH];

    logic fall;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic ovf_set;
    logic valid;

    assign fall  = c3_q & ~c2_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0])
                 & (wr_q[FIFO_AW] != rd_q[FIFO_AW]);
    assign pop   = rdn_q & ~bus.rdn & ~empty;
    // Start low, stop high, odd parity over data plus parity bit.
    assign valid = ~start_q & sr_q[9] & (^sr_q[8:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        start_d = start_q;
        idle_d  = idle_q;
        err_d   = 1'b0;
        push    = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idle_d = '0;
                if (fall) begin
                    if (!d2_q) begin
                        start_d = d2_q;
                        cnt_d   = 4'd1;
                        state_d = S_RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (fall) begin
                    sr_d   = {d2_q, sr_q[9:1]};
                    cnt_d  = cnt_q + 4'd1;
                    idle_d = '0;
                    if (cnt_q == 4'd10) begin
                        state_d = S_CHECK;
                    end
                end else if (idle_q == TMAX) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    idle_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + TONE;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                if (!valid) begin
                    err_d = 1'b1;
                end else if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d  = wr_q + {{FIFO_AW{1'b0}}, push};
        rd_d  = rd_q + {{FIFO_AW{1'b0}}, pop};
        ovf_d = ovf_q;
        if (pop) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sr_q    <= '0;
            start_q <= 1'b1;
            idle_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            rdn_q   <= 1'b1;
            c1_q    <= 1'b1;
            c2_q    <= 1'b1;
            c3_q    <= 1'b1;
            d1_q    <= 1'b1;
            d2_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            start_q <= start_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdn_q   <= bus.rdn;
            c1_q    <= ps2_clk;
            c2_q    <= c1_q;
            c3_q    <= c2_q;
            d1_q    <= ps2_data;
            d2_q    <= d1_q;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[FIFO_AW-1:0]] <= sr_q[7:0];
        end
    end

    assign bus.data      = mem_q[rd_q[FIFO_AW-1:0]];
    assign bus.ready     = ~empty;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = err_q;
endmodule
